// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the multi-cycle core.
// Runs fetch, then branch resolve, then an optional flush window after a redirect.
module pc_sequencer #(
  parameter int unsigned           PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC     = '0,
  parameter int unsigned           FLUSH_CYCLES = 2
) (
  input  logic                in_clk,
  input  logic                in_rst_n,
  input  logic                in_stall,
  output logic                out_imem_req,
  input  logic                in_imem_ack,
  input  logic                in_resolve,
  input  logic                in_ctrl_branch,
  input  logic                in_ctrl_btype,
  input  logic                in_ctrl_jump,
  input  logic                in_flag_neg,
  input  logic                in_flag_zero,
  input  logic [PC_WIDTH-1:0] in_target,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic                out_pc_valid,
  output logic                out_taken,
  output logic                out_flush
);

  // state   | meaning
  // BOOT    | one idle cycle after reset release
  // FETCH   | request instruction at out_pc, wait for ack
  // RESOLVE | wait for an unstalled resolve from execute
  // FLUSH   | squash wrong-path work for FLUSH_CYCLES cycles
  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    FETCH   = 2'd1,
    RESOLVE = 2'd2,
    FLUSH   = 2'd3
  } state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_t               state;
  logic [3:0]           flush_cnt;
  logic [PC_WIDTH-1:0]  pc;
  logic                 pc_valid;
  logic                 taken;
  logic                 take;

  assign take = in_ctrl_jump
              | (in_ctrl_branch & ~in_ctrl_btype & in_flag_zero)
              | (in_ctrl_branch &  in_ctrl_btype & in_flag_neg);

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      pc_valid  <= 1'b0;
      taken     <= 1'b0;
      flush_cnt <= 4'd0;
    end else begin
      pc_valid <= 1'b0;
      taken    <= 1'b0;
      case (state)
        BOOT: state <= FETCH;
        FETCH: begin
          if (in_imem_ack) begin
            state    <= RESOLVE;
            pc_valid <= 1'b1;
          end
        end
        RESOLVE: begin
          // a stalled resolve is not a decision; execute re-presents it later
          if (in_resolve && !in_stall) begin
            if (take) begin
              pc        <= in_target;
              taken     <= 1'b1;
              flush_cnt <= FLUSH_INIT;
              state     <= FLUSH;
            end else begin
              pc    <= pc + PC_WIDTH'(1);
              state <= FETCH;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt <= 4'd1) begin
            flush_cnt <= 4'd0;
            state     <= FETCH;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  // req and flush decode from state so an async reset drops them instantly
  assign out_imem_req = (state == FETCH);
  assign out_flush    = (state == FLUSH);
  assign out_pc       = pc;
  assign out_pc_valid = pc_valid;
  assign out_taken    = taken;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues expected fetch PCs and redirect
// targets, a negedge monitor pops them on each pc_valid / taken pulse.
module tb_pc_sequencer;

  localparam int FLUSH_N = 2;

  logic        in_clk;
  logic        in_rst_n;
  logic        in_stall;
  logic        out_imem_req;
  logic        in_imem_ack;
  logic        in_resolve;
  logic        in_ctrl_branch;
  logic        in_ctrl_btype;
  logic        in_ctrl_jump;
  logic        in_flag_neg;
  logic        in_flag_zero;
  logic [31:0] in_target;
  logic [31:0] out_pc;
  logic        out_pc_valid;
  logic        out_taken;
  logic        out_flush;

  pc_sequencer #(
    .PC_WIDTH     (32),
    .RESET_PC     (32'h0),
    .FLUSH_CYCLES (FLUSH_N)
  ) dut (
    .in_clk         (in_clk),
    .in_rst_n       (in_rst_n),
    .in_stall       (in_stall),
    .out_imem_req   (out_imem_req),
    .in_imem_ack    (in_imem_ack),
    .in_resolve     (in_resolve),
    .in_ctrl_branch (in_ctrl_branch),
    .in_ctrl_btype  (in_ctrl_btype),
    .in_ctrl_jump   (in_ctrl_jump),
    .in_flag_neg    (in_flag_neg),
    .in_flag_zero   (in_flag_zero),
    .in_target      (in_target),
    .out_pc         (out_pc),
    .out_pc_valid   (out_pc_valid),
    .out_taken      (out_taken),
    .out_flush      (out_flush)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  int passed = 0;
  int total  = 0;
  logic [31:0] pc_q[$];
  logic [31:0] tgt_q[$];
  logic [31:0] exp_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // monitor: every pc_valid / taken pulse must match the next queued expectation
  always @(negedge in_clk) begin
    if (in_rst_n) begin
      if (out_pc_valid) begin
        if (pc_q.size() == 0) check("pc_valid_unexpected", out_pc, 32'hDEAD_BEEF);
        else check("pc_valid_pc", out_pc, pc_q.pop_front());
      end
      if (out_taken) begin
        if (tgt_q.size() == 0) check("taken_unexpected", out_pc, 32'hDEAD_BEEF);
        else check("taken_target", out_pc, tgt_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_ctrl();
    in_resolve     = 1'b0;
    in_ctrl_branch = 1'b0;
    in_ctrl_btype  = 1'b0;
    in_ctrl_jump   = 1'b0;
    in_flag_neg    = 1'b0;
    in_flag_zero   = 1'b0;
    in_target      = 32'h0;
  endtask

  // called at a negedge; waits for FETCH, holds ack low for 'delay' cycles
  task automatic do_fetch(input int delay);
    int n;
    n = 0;
    while (!out_imem_req && n < 10) begin
      @(negedge in_clk);
      n++;
    end
    check("fetch_req", {31'b0, out_imem_req}, 32'd1);
    pc_q.push_back(exp_pc);
    for (int i = 0; i < delay; i++) begin
      check("fetch_pc_stable", out_pc, exp_pc);
      @(negedge in_clk);
      check("fetch_req_hold", {31'b0, out_imem_req}, 32'd1);
    end
    in_imem_ack = 1'b1;
    @(negedge in_clk);
    in_imem_ack = 1'b0;
    check("fetch_req_drop", {31'b0, out_imem_req}, 32'd0);
  endtask

  // called at a negedge in RESOLVE
  task automatic do_resolve(input logic br, input logic bt, input logic jmp, input logic neg,
                            input logic zero, input logic [31:0] tgt, input logic exp_taken);
    int n;
    in_ctrl_branch = br;
    in_ctrl_btype  = bt;
    in_ctrl_jump   = jmp;
    in_flag_neg    = neg;
    in_flag_zero   = zero;
    in_target      = tgt;
    in_resolve     = 1'b1;
    if (exp_taken) tgt_q.push_back(tgt);
    @(negedge in_clk);
    clear_ctrl();
    if (exp_taken) begin
      check("taken_pulse", {31'b0, out_taken}, 32'd1);
      n = 0;
      while (out_flush && n < 20) begin
        n++;
        @(negedge in_clk);
      end
      check("flush_len", n, FLUSH_N);
      exp_pc = tgt;
    end else begin
      check("nt_no_taken", {31'b0, out_taken}, 32'd0);
      check("nt_no_flush", {31'b0, out_flush}, 32'd0);
      exp_pc = exp_pc + 32'd1;
    end
    check("next_req", {31'b0, out_imem_req}, 32'd1);
    check("next_pc", out_pc, exp_pc);
  endtask

  initial begin
    int n;
    in_rst_n    = 1'b0;
    in_stall    = 1'b0;
    in_imem_ack = 1'b0;
    clear_ctrl();
    #1;
    check("rst_pc", out_pc, 32'h0);
    check("rst_req", {31'b0, out_imem_req}, 32'd0);
    check("rst_outs", {29'b0, out_pc_valid, out_taken, out_flush}, 32'd0);
    repeat (2) @(negedge in_clk);
    in_rst_n = 1'b1;
    #1;
    check("boot_no_req", {31'b0, out_imem_req}, 32'd0);

    // 1: ack and resolve tied high, three sequential PCs
    pc_q.push_back(32'd0);
    pc_q.push_back(32'd1);
    pc_q.push_back(32'd2);
    in_imem_ack = 1'b1;
    in_resolve  = 1'b1;
    n = 0;
    @(negedge in_clk);
    while (!(out_pc_valid && out_pc == 32'd2) && n < 40) begin
      @(negedge in_clk);
      n++;
    end
    in_imem_ack = 1'b0;
    in_resolve  = 1'b0;
    check("seq_reached_pc2", out_pc, 32'd2);
    exp_pc = 32'd2;

    // 2: delayed ack
    do_resolve(0, 0, 0, 0, 0, 32'h0, 0);
    do_fetch(3);

    // 3: BRZ taken then not taken
    do_resolve(1, 0, 0, 0, 1, 32'h40, 1);
    do_fetch(0);
    do_resolve(1, 0, 0, 0, 0, 32'h99, 0);
    do_fetch(1);

    // 4: BRN and jump
    do_resolve(1, 1, 0, 1, 0, 32'h80, 1);
    do_fetch(0);
    do_resolve(1, 0, 0, 1, 0, 32'h77, 0);
    do_fetch(0);
    do_resolve(0, 0, 1, 0, 0, 32'h100, 1);
    do_fetch(2);
    do_resolve(1, 0, 1, 0, 0, 32'h200, 1);
    do_fetch(0);

    // 5: stall holds the update, then wrap at all-ones
    in_resolve = 1'b1;
    in_stall   = 1'b1;
    repeat (3) begin
      @(negedge in_clk);
      check("stall_pc_hold", out_pc, exp_pc);
      check("stall_no_fetch", {30'b0, out_imem_req, out_flush}, 32'd0);
    end
    in_stall = 1'b0;
    @(negedge in_clk);
    in_resolve = 1'b0;
    exp_pc = exp_pc + 32'd1;
    check("stall_release_pc", out_pc, exp_pc);
    check("stall_release_req", {31'b0, out_imem_req}, 32'd1);
    do_fetch(0);
    do_resolve(0, 0, 1, 0, 0, 32'hFFFF_FFFF, 1);
    do_fetch(0);
    do_resolve(0, 0, 0, 0, 0, 32'h0, 0);
    check("wrap_pc", out_pc, 32'h0);

    // 6a: reset in FETCH
    do_fetch(0);
    do_resolve(0, 0, 0, 0, 0, 32'h0, 0);
    in_rst_n = 1'b0;
    #1;
    check("rst_fetch_req", {31'b0, out_imem_req}, 32'd0);
    check("rst_fetch_pc", out_pc, 32'h0);
    @(negedge in_clk);
    in_rst_n = 1'b1;
    #1;
    check("reboot_no_req", {31'b0, out_imem_req}, 32'd0);
    @(negedge in_clk);
    exp_pc = 32'h0;
    do_fetch(0);

    // 6b: reset in FLUSH
    in_ctrl_jump = 1'b1;
    in_target    = 32'h30;
    in_resolve   = 1'b1;
    tgt_q.push_back(32'h30);
    @(negedge in_clk);
    clear_ctrl();
    check("pre_rst_flush", {31'b0, out_flush}, 32'd1);
    #1;
    in_rst_n = 1'b0;
    #1;
    check("rst_flush_flush", {31'b0, out_flush}, 32'd0);
    check("rst_flush_pc", out_pc, 32'h0);
    check("rst_flush_taken", {31'b0, out_taken}, 32'd0);
    @(negedge in_clk);
    in_rst_n = 1'b1;
    exp_pc = 32'h0;
    @(negedge in_clk);
    do_fetch(0);
    do_resolve(0, 0, 0, 0, 0, 32'h0, 0);

    repeat (2) @(negedge in_clk);
    check("pc_q_drained", pc_q.size(), 32'd0);
    check("tgt_q_drained", tgt_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
